// File: rtl/i2c_reg_sequencer.sv
// Host register access front end for the I2C byte engine: issues START/WRITE/RESTART/READ/STOP
// one command at a time and reports done/err/rdata. Define I2C_SEQ_TIMEOUT_EN for the response watchdog.
module i2c_reg_sequencer #(
    parameter int unsigned CMD_W          = 3,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [6:0]       req_dev,
    input  logic [7:0]       req_reg,
    input  logic [7:0]       req_wdata,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [CMD_W-1:0] cmd_code,
    output logic [7:0]       cmd_data,
    input  logic             rsp_valid,
    input  logic             rsp_nack,
    input  logic [7:0]       rsp_data,
    output logic             done,
    output logic             err,
    output logic [7:0]       rdata
);

    localparam logic [CMD_W-1:0] CMD_NOP       = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_START     = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_WRITE     = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_READ_NACK = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_RESTART   = CMD_W'(4);
    localparam logic [CMD_W-1:0] CMD_STOP      = CMD_W'(5);

    typedef enum logic [1:0] {PH_IDLE, PH_ISSUE, PH_WAIT} phase_t;
    typedef enum logic [2:0] {
        ST_START, ST_ADDR_W, ST_REG, ST_DATA, ST_RESTART, ST_ADDR_R, ST_READ, ST_STOP
    } step_t;

    phase_t      phase;
    step_t       step;
    step_t       next_step;
    logic        rw_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q;
    logic [7:0]  wdata_q;
    logic        err_flag;

    function automatic step_t step_after(step_t s, logic rw);
        case (s)
            ST_START:   step_after = ST_ADDR_W;
            ST_ADDR_W:  step_after = ST_REG;
            ST_REG:     step_after = rw ? ST_RESTART : ST_DATA;
            ST_RESTART: step_after = ST_ADDR_R;
            ST_ADDR_R:  step_after = ST_READ;
            default:    step_after = ST_STOP;
        endcase
    endfunction

    function automatic logic is_write(step_t s);
        is_write = (s == ST_ADDR_W) || (s == ST_REG) || (s == ST_DATA) || (s == ST_ADDR_R);
    endfunction

    function automatic logic [CMD_W-1:0] step_code(step_t s);
        case (s)
            ST_START:   step_code = CMD_START;
            ST_RESTART: step_code = CMD_RESTART;
            ST_READ:    step_code = CMD_READ_NACK;
            ST_STOP:    step_code = CMD_STOP;
            default:    step_code = CMD_WRITE;
        endcase
    endfunction

    function automatic logic [7:0] step_byte(step_t s, logic [6:0] dev, logic [7:0] rg,
                                             logic [7:0] wd);
        case (s)
            ST_ADDR_W: step_byte = {dev, 1'b0};
            ST_REG:    step_byte = rg;
            ST_DATA:   step_byte = wd;
            ST_ADDR_R: step_byte = {dev, 1'b1};
            default:   step_byte = 8'h00;
        endcase
    endfunction

    // A NACKed address/data byte skips the rest of the transfer and goes straight to STOP
    always_comb begin
        next_step = step_after(step, rw_q);
        if (is_write(step) && rsp_nack) begin
            next_step = ST_STOP;
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        timeout_hit;
    assign timeout_hit = (({1'b0, wait_cnt} + 17'd1) >= {1'b0, TIMEOUT_CYCLES});
`else
    localparam logic [15:0] timeout_unused = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= PH_IDLE;
            step      <= ST_START;
            rw_q      <= 1'b0;
            dev_q     <= 7'h00;
            reg_q     <= 8'h00;
            wdata_q   <= 8'h00;
            err_flag  <= 1'b0;
            req_ready <= 1'b1;
            cmd_valid <= 1'b0;
            cmd_code  <= CMD_NOP;
            cmd_data  <= 8'h00;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 8'h00;
`ifdef I2C_SEQ_TIMEOUT_EN
            wait_cnt  <= 16'h0000;
`endif
        end else begin
            done <= 1'b0;
            case (phase)
                PH_IDLE: begin
                    if (req_valid && req_ready) begin
                        rw_q      <= req_rw;
                        dev_q     <= req_dev;
                        reg_q     <= req_reg;
                        wdata_q   <= req_wdata;
                        err_flag  <= 1'b0;
                        err       <= 1'b0;
                        req_ready <= 1'b0;
                        step      <= ST_START;
                        phase     <= PH_ISSUE;
                        cmd_valid <= 1'b1;
                        cmd_code  <= CMD_START;
                        cmd_data  <= 8'h00;
                    end
                end
                PH_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        phase     <= PH_WAIT;
`ifdef I2C_SEQ_TIMEOUT_EN
                        wait_cnt  <= 16'h0000;
`endif
                    end
                end
                PH_WAIT: begin
                    if (rsp_valid) begin
                        if (step == ST_STOP) begin
                            phase     <= PH_IDLE;
                            done      <= 1'b1;
                            err       <= err_flag;
                            req_ready <= 1'b1;
                        end else begin
                            if (step == ST_READ) begin
                                rdata <= rsp_data;
                            end
                            if (is_write(step) && rsp_nack) begin
                                err_flag <= 1'b1;
                            end
                            step      <= next_step;
                            phase     <= PH_ISSUE;
                            cmd_valid <= 1'b1;
                            cmd_code  <= step_code(next_step);
                            cmd_data  <= step_byte(next_step, dev_q, reg_q, wdata_q);
                        end
                    end
`ifdef I2C_SEQ_TIMEOUT_EN
                    // Silent engine: abandon the step; a silent STOP still closes the transaction
                    else if (timeout_hit) begin
                        if (step == ST_STOP) begin
                            phase     <= PH_IDLE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                            req_ready <= 1'b1;
                        end else begin
                            err_flag  <= 1'b1;
                            step      <= ST_STOP;
                            phase     <= PH_ISSUE;
                            cmd_valid <= 1'b1;
                            cmd_code  <= CMD_STOP;
                            cmd_data  <= 8'h00;
                        end
                    end else if (wait_cnt != 16'hFFFF) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Table-driven bench for i2c_reg_sequencer with a behavioural I2C engine model and hand-built
// sequences for back-to-back requests, mid-transaction reset and the optional watchdog.
module tb_i2c_reg_sequencer;

    localparam logic [2:0] C_START   = 3'd1;
    localparam logic [2:0] C_WRITE   = 3'd2;
    localparam logic [2:0] C_READ    = 3'd3;
    localparam logic [2:0] C_RESTART = 3'd4;
    localparam logic [2:0] C_STOP    = 3'd5;
    localparam int NV = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_wdata;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_code;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_nack;
    logic [7:0] rsp_data;
    logic       done;
    logic       err;
    logic [7:0] rdata;

    i2c_reg_sequencer #(.CMD_W(3), .TIMEOUT_CYCLES(16'd20)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_dev   (req_dev),
        .req_reg   (req_reg),
        .req_wdata (req_wdata),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_nack  (rsp_nack),
        .rsp_data  (rsp_data),
        .done      (done),
        .err       (err),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic            rw;
        logic [6:0]      dev;
        logic [7:0]      rg;
        logic [7:0]      wd;
        logic [7:0]      rd;
        int              nack_at;
        int              ready_dly;
        int              rsp_dly;
        logic            ready_high;
        logic            nack_other;
        logic            spurious;
        int              ncmd;
        logic [6:0][2:0] codes;
        logic [6:0][7:0] datas;
        logic            exp_err;
        logic [7:0]      exp_rdata;
        int              exp_lat;
    } vec_t;

    vec_t vecs[NV];

    // Engine model configuration (written by the main sequence only)
    int         e_ready_dly = 0;
    int         e_rsp_dly = 0;
    logic       e_ready_high = 1'b0;
    logic       e_nack_other = 1'b0;
    logic       e_spurious = 1'b0;
    int         e_nack_at = -1;
    int         e_hang_at = -1;
    logic [7:0] e_rd = 8'h00;
    int         flush_req = 0;

    // Engine model state and transfer log (written by the engine only)
    logic [2:0] log_code[$];
    logic [7:0] log_data[$];
    int         log_cyc[$];
    int         stab_errs = 0;

    int passed = 0;
    int total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    initial begin : engine
        logic       armed;
        logic       outstanding;
        logic [2:0] cur;
        logic [2:0] seen_code;
        logic [7:0] seen_data;
        int         stall;
        int         cnt;
        int         nxfer;
        int         wr_idx;
        int         flush_ack;
        armed = 0; outstanding = 0; cur = 3'd0; seen_code = 3'd0; seen_data = 8'h00;
        stall = 0; cnt = 0; nxfer = 0; wr_idx = 0; flush_ack = 0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            if (flush_req != flush_ack) begin
                flush_ack = flush_req;
                armed = 0; outstanding = 0; stall = 0; nxfer = 0; wr_idx = 0;
                log_code.delete(); log_data.delete(); log_cyc.delete();
                stab_errs = 0;
                cmd_ready = e_ready_high;
            end
            if (armed) begin
                log_code.push_back(seen_code);
                log_data.push_back(seen_data);
                log_cyc.push_back(cyc);
                armed = 0; outstanding = 1; cur = seen_code; cnt = e_rsp_dly; stall = 0;
                nxfer++;
                cmd_ready = e_ready_high;
            end
            if (outstanding) begin
                if (cmd_valid) stab_errs++;
                if (e_hang_at >= 0 && nxfer >= e_hang_at && cur != C_STOP) begin
                    cnt = cnt;
                end else if (cnt > 0) begin
                    cnt--;
                end else begin
                    rsp_valid = 1'b1;
                    rsp_data  = e_rd;
                    if (cur == C_WRITE) begin
                        rsp_nack = (wr_idx == e_nack_at);
                        wr_idx++;
                    end else begin
                        rsp_nack = e_nack_other;
                    end
                    outstanding = 0;
                end
            end else if (cmd_valid) begin
                if (stall == 0) begin
                    seen_code = cmd_code;
                    seen_data = cmd_data;
                end else if (cmd_code !== seen_code || cmd_data !== seen_data) begin
                    stab_errs++;
                end
                if (stall >= e_ready_dly) begin
                    cmd_ready = 1'b1;
                    armed = 1;
                end else begin
                    if (e_spurious) begin
                        rsp_valid = 1'b1;
                        rsp_nack  = 1'b1;
                        rsp_data  = 8'hEE;
                    end
                    cmd_ready = e_ready_high;
                    stall++;
                end
            end
        end
    end

    function automatic vec_t mk(logic rw, logic [6:0] dev, logic [7:0] rg, logic [7:0] wd,
                                logic [7:0] rd, int nack_at, int rdly, int sdly, logic rh,
                                logic no, logic sp, logic e_err, logic [7:0] e_rdata, int lat);
        vec_t v;
        v = '0;
        v.rw = rw; v.dev = dev; v.rg = rg; v.wd = wd; v.rd = rd; v.nack_at = nack_at;
        v.ready_dly = rdly; v.rsp_dly = sdly; v.ready_high = rh; v.nack_other = no;
        v.spurious = sp; v.exp_err = e_err; v.exp_rdata = e_rdata; v.exp_lat = lat;
        return v;
    endfunction

    function automatic void put(int i, logic [2:0] c, logic [7:0] d);
        vecs[i].codes[vecs[i].ncmd] = c;
        vecs[i].datas[vecs[i].ncmd] = d;
        vecs[i].ncmd = vecs[i].ncmd + 1;
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic cfg(input int rdly, input int sdly, input logic rh, input logic no,
                       input logic sp, input int nk, input int hang, input logic [7:0] rd);
        e_ready_dly = rdly; e_rsp_dly = sdly; e_ready_high = rh; e_nack_other = no;
        e_spurious = sp; e_nack_at = nk; e_hang_at = hang; e_rd = rd;
        flush_req++;
    endtask

    task automatic start_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [7:0] wd);
        req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   lat;
        v = vecs[i];
        cfg(v.ready_dly, v.rsp_dly, v.ready_high, v.nack_other, v.spurious, v.nack_at, -1, v.rd);
        check($sformatf("v%0d_idle_ready", i), 32'(req_ready), 32'd1);
        start_req(v.rw, v.dev, v.rg, v.wd);
        check($sformatf("v%0d_first_cmd", i), 32'(cmd_valid), 32'd1);
        wait_done(lat);
        check($sformatf("v%0d_latency", i), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d_done_ready", i), 32'(req_ready), 32'd1);
        check($sformatf("v%0d_ncmd", i), 32'(log_code.size()), 32'(v.ncmd));
        for (int k = 0; k < v.ncmd && k < log_code.size(); k++) begin
            check($sformatf("v%0d_code%0d", i, k), 32'(log_code[k]), 32'(v.codes[k]));
            if (v.codes[k] == C_WRITE)
                check($sformatf("v%0d_data%0d", i, k), 32'(log_data[k]), 32'(v.datas[k]));
        end
        check($sformatf("v%0d_err", i), 32'(err), 32'(v.exp_err));
        check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(v.exp_rdata));
        check($sformatf("v%0d_stable", i), 32'(stab_errs), 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
        check($sformatf("v%0d_err_held", i), 32'(err), 32'(v.exp_err));
    endtask

    initial begin : main
        int n;
        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0;
        req_dev = 7'h00; req_reg = 8'h00; req_wdata = 8'h00;

        for (int i = 0; i < NV; i++) vecs[i] = '0;
        vecs[0] = mk(0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, 0, 0, 0, 0, 0, 0, 8'h00, 10);
        put(0, C_START, 8'h00); put(0, C_WRITE, 8'hA0); put(0, C_WRITE, 8'h10);
        put(0, C_WRITE, 8'hA5); put(0, C_STOP, 8'h00);
        vecs[1] = mk(1, 7'h50, 8'h22, 8'h00, 8'h5C, -1, 0, 0, 0, 0, 0, 0, 8'h5C, 14);
        put(1, C_START, 8'h00); put(1, C_WRITE, 8'hA0); put(1, C_WRITE, 8'h22);
        put(1, C_RESTART, 8'h00); put(1, C_WRITE, 8'hA1); put(1, C_READ, 8'h00);
        put(1, C_STOP, 8'h00);
        vecs[2] = mk(0, 7'h50, 8'h33, 8'h11, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h5C, 6);
        put(2, C_START, 8'h00); put(2, C_WRITE, 8'hA0); put(2, C_STOP, 8'h00);
        vecs[3] = mk(1, 7'h3C, 8'h44, 8'h00, 8'h99, 1, 0, 0, 0, 0, 0, 1, 8'h5C, 8);
        put(3, C_START, 8'h00); put(3, C_WRITE, 8'h78); put(3, C_WRITE, 8'h44);
        put(3, C_STOP, 8'h00);
        vecs[4] = mk(0, 7'h7F, 8'hFF, 8'h00, 8'h00, -1, 7, 0, 0, 0, 0, 0, 8'h5C, 45);
        put(4, C_START, 8'h00); put(4, C_WRITE, 8'hFE); put(4, C_WRITE, 8'hFF);
        put(4, C_WRITE, 8'h00); put(4, C_STOP, 8'h00);
        vecs[5] = mk(1, 7'h01, 8'h00, 8'h00, 8'hA7, -1, 0, 3, 1, 1, 0, 0, 8'hA7, 35);
        put(5, C_START, 8'h00); put(5, C_WRITE, 8'h02); put(5, C_WRITE, 8'h00);
        put(5, C_RESTART, 8'h00); put(5, C_WRITE, 8'h03); put(5, C_READ, 8'h00);
        put(5, C_STOP, 8'h00);
        vecs[6] = mk(1, 7'h2A, 8'h80, 8'h00, 8'h11, 2, 0, 0, 0, 0, 0, 1, 8'hA7, 12);
        put(6, C_START, 8'h00); put(6, C_WRITE, 8'h54); put(6, C_WRITE, 8'h80);
        put(6, C_RESTART, 8'h00); put(6, C_WRITE, 8'h55); put(6, C_STOP, 8'h00);
        vecs[7] = mk(1, 7'h12, 8'h34, 8'h00, 8'h3E, -1, 2, 0, 0, 0, 1, 0, 8'h3E, 28);
        put(7, C_START, 8'h00); put(7, C_WRITE, 8'h24); put(7, C_WRITE, 8'h34);
        put(7, C_RESTART, 8'h00); put(7, C_WRITE, 8'h25); put(7, C_READ, 8'h00);
        put(7, C_STOP, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_code", 32'(cmd_code), 32'd0);
        check("rst_cmd_data", 32'(cmd_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Back-to-back: req_valid held high, busy-time request fields must be ignored
        cfg(0, 0, 0, 0, 0, -1, -1, 8'h00);
        req_rw = 1'b0; req_dev = 7'h0A; req_reg = 8'h22; req_wdata = 8'h33; req_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_busy_ready", 32'(req_ready), 32'd0);
        req_dev = 7'h44; req_reg = 8'h55; req_wdata = 8'h66;
        wait_done(n);
        check("b2b_first_lat", 32'(n), 32'd10);
        check("b2b_first_ncmd", 32'(log_data.size()), 32'd5);
        if (log_data.size() == 5) begin
            check("b2b_first_dev", 32'(log_data[1]), 32'h14);
            check("b2b_first_reg", 32'(log_data[2]), 32'h22);
            check("b2b_first_wd", 32'(log_data[3]), 32'h33);
        end
        check("b2b_done_ready", 32'(req_ready), 32'd1);
        flush_req++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_second_valid", 32'(cmd_valid), 32'd1);
        check("b2b_second_code", 32'(cmd_code), 32'(C_START));
        check("b2b_second_ready", 32'(req_ready), 32'd0);
        wait_done(n);
        check("b2b_second_ncmd", 32'(log_data.size()), 32'd5);
        if (log_data.size() == 5) begin
            check("b2b_second_dev", 32'(log_data[1]), 32'h88);
            check("b2b_second_reg", 32'(log_data[2]), 32'h55);
            check("b2b_second_wd", 32'(log_data[3]), 32'h66);
        end
        check("b2b_second_err", 32'(err), 32'd0);
        @(posedge clk); #1;

        // Reset in the WAIT after the register byte
        cfg(0, 0, 0, 0, 0, -1, 3, 8'h00);
        start_req(1'b0, 7'h50, 8'h10, 8'hA5);
        n = 0;
        while (log_code.size() < 3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_reach_reg", 32'(log_code.size()), 32'd3);
        check("mid_wait_valid", 32'(cmd_valid), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_valid", 32'(cmd_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("mid_no_stop", 32'(log_code.size()), 32'd3);
        run_vec(0);

`ifdef I2C_SEQ_TIMEOUT_EN
        // Engine goes silent after the address byte; watchdog forces STOP
        cfg(0, 0, 0, 0, 0, -1, 2, 8'h00);
        start_req(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done(n);
        check("to_done", 32'(done), 32'd1);
        check("to_ncmd", 32'(log_code.size()), 32'd3);
        if (log_code.size() == 3) begin
            check("to_stop_code", 32'(log_code[2]), 32'(C_STOP));
            check("to_gap", 32'(log_cyc[2] - log_cyc[1]), 32'd21);
        end
        check("to_err", 32'(err), 32'd1);
        @(posedge clk); #1;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
- Transaction front end sitting directly upstream of the I2C bit/byte engine (the block owning the k_idle … k_stop2 state machine).
- Converts one host register access (7-bit device address, 8-bit register address, optional write data) into the ordered command stream the engine consumes: START, address/data bytes, RESTART, READ, STOP.
- Collects the engine's per-command responses and reports completion, read data and NACK errors to the host.

Parameters:
- CMD_W, 3, width of the engine command code.
- TIMEOUT_CYCLES, 16'hFFFF, response watchdog limit; used only with I2C_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  host request strobe.
- req_ready  out  1  high when idle; the request is accepted on req_valid & req_ready.
- req_rw  in  1  0 = write, 1 = read.
- req_dev  in  7  device address.
- req_reg  in  8  register address.
- req_wdata  in  8  write data.
- cmd_valid  out  1  command to the engine is valid.
- cmd_ready  in  1  engine accepts the command.
- cmd_code  out  3  command code: 0 NOP, 1 START, 2 WRITE, 3 READ_NACK, 4 RESTART, 5 STOP.
- cmd_data  out  8  byte for WRITE.
- rsp_valid  in  1  one-cycle pulse; the engine has finished the last command.
- rsp_nack  in  1  slave NACKed a WRITE; qualified by rsp_valid.
- rsp_data  in  8  byte returned by READ_NACK; qualified by rsp_valid.
- done  out  1  one-cycle completion pulse.
- err  out  1  status of the last transaction; valid with done and held until the next accept.
- rdata  out  8  read result; held until the next accept.

Behaviour:
- Reset values:
  - req_ready = 1.
  - cmd_valid = 0, cmd_code = 0, cmd_data = 0.
  - done = 0, err = 0, rdata = 0.
  - FSM = IDLE.
- Reset applied mid-transaction returns to IDLE on that edge. cmd_valid drops on the same edge. No STOP is issued.
- Request inputs are registered on accept. Inputs are ignored while busy.
- Step states:
  - Write: START → ADDR_W (cmd_data = {dev,0}) → REG (req_reg) → DATA (req_wdata) → STOP.
  - Read: START → ADDR_W → REG → RESTART → ADDR_R (cmd_data = {dev,1}) → READ → STOP.
- Each step has two phases, ISSUE and WAIT:
  - ISSUE: cmd_valid = 1 and cmd_code/cmd_data are stable until cmd_ready; the transfer happens on cmd_valid & cmd_ready.
  - WAIT: cmd_valid = 0 until rsp_valid; the next step's ISSUE starts the cycle after rsp_valid.
- Exactly one outstanding command at any time.
- rsp_valid arriving in ISSUE (no command outstanding) is ignored.
- NACK handling:
  - rsp_valid & rsp_nack after any WRITE step sets the sticky error flag and jumps directly to STOP.
  - rsp_nack on START, RESTART, READ and STOP responses is ignored.
- READ response: rdata ← rsp_data.
- Completion: the STOP response drives done = 1 for one cycle, err = sticky flag, FSM = IDLE, and req_ready = 1 in the same cycle as done.
- Back-to-back requests: a req_valid held high is accepted in the done cycle. The next START is issued one cycle later.
- Latency from accept to first cmd_valid = 1 cycle.
- Minimum write transaction, engine responding in zero wait: cycles = 1 + 5×2 + 1.
- Accept clears err and done.
- cmd_ready held high while in WAIT has no effect.

Optional Feature:
- Macro: I2C_SEQ_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter clears on every ISSUE→WAIT transition and increments in WAIT.
  - When the counter reaches TIMEOUT_CYCLES and the current step is not STOP: set err, jump to STOP.
  - A timeout in the STOP step ends the transaction: done pulse with err = 1.
  - The counter saturates and never wraps.
- Without the macro: no counter is present and WAIT lasts indefinitely.

Test Plan:
- Write: dev = 7'h50, reg = 8'h10, wdata = 8'hA5, engine never NACKs.
  - Command sequence must be START, WRITE 8'hA0, WRITE 8'h10, WRITE 8'hA5, STOP.
  - done pulses once, err = 0.
- Read: dev = 7'h50, reg = 8'h22, engine returns 8'h5C.
  - Command sequence must be START, WRITE A0, WRITE 22, RESTART, WRITE A1, READ_NACK, STOP.
  - rdata = 8'h5C, err = 0.
- NACK on the address byte: rsp_nack = 1 on the first WRITE.
  - Next command must be STOP, with no REG byte.
  - done with err = 1.
- Backpressure: cmd_ready held low for 7 cycles on each command.
  - cmd_code/cmd_data stable throughout, exactly one transfer per step.
  - req_valid asserted while busy is not accepted (req_ready = 0).
- Reset asserted in the WAIT after REG.
  - Next cycle: cmd_valid = 0, req_ready = 1, err = 0, done = 0.
  - A new request then runs a full sequence.
- With I2C_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 20, no rsp after ADDR_W.
  - STOP is issued after 20 WAIT cycles.
  - After the STOP response: done with err = 1.
